// File: rtl/lb_pkg.sv
// Shared types and constants for the scanline prefetch controller.
// The optional stats feature (LB_UNDERRUN_STATS_EN) adds no package content.
package lb_pkg;

  localparam int unsigned WORD_W       = 128;
  localparam int unsigned PIX_W        = 16;
  localparam int unsigned ADDR_W       = 22;
  localparam int unsigned PIX_PER_WORD = 8;
  localparam int unsigned LANE_W       = $clog2(PIX_PER_WORD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } lb_state_e;

  // Select one 16-bit pixel lane out of a 128-bit line-store word.
  function automatic logic [PIX_W-1:0] lb_pix_lane(input logic [WORD_W-1:0] word,
                                                   input logic [LANE_W-1:0] lane);
    return word[lane * PIX_W +: PIX_W];
  endfunction

endpackage

// File: rtl/lb_line_ram.sv
// Ping-pong line store: simple dual-port RAM, one write port, one read port
// with a registered read (one cycle of latency). No reset so it maps to
// block RAM.
module lb_line_ram
  import lb_pkg::*;
#(
  parameter int unsigned DEPTH = 160,
  parameter int unsigned AW    = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Write port from the fetch side, registered read for the pixel side.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lb_fetch_ctrl.sv
// Scanline prefetch controller: fetches the next visible line from SDRAM
// during horizontal blank into the back half of a ping-pong line store and
// serves pixels from the front half.
// Optional macro LB_UNDERRUN_STATS_EN adds underrun_cnt/underrun_flag outputs.
module lb_fetch_ctrl
  import lb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] FB_BASE        = 22'h000000,
  parameter int unsigned       WORDS_PER_LINE = 80,
  parameter int unsigned       H_ACTIVE       = 640,
  parameter int unsigned       V_ACTIVE       = 480,
  parameter int unsigned       V_TOTAL        = 525,
  parameter int unsigned       TRIG_X         = 798
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic              lb_sdram_rd,
  output logic [ADDR_W-1:0] lb_sdram_addr,
  input  logic              lb_sdram_Wait,
  input  logic              lb_sdram_ac,
  input  logic [WORD_W-1:0] lb_sdram_data,
  output logic              lb_Busy,
  output logic              lb_done,
  output logic [PIX_W-1:0]  pix_data
`ifdef LB_UNDERRUN_STATS_EN
  ,
  output logic [15:0]       underrun_cnt,
  output logic              underrun_flag
`endif
);

  localparam int unsigned CNT_W  = $clog2(WORDS_PER_LINE + 1);
  localparam int unsigned RAM_AW = $clog2(2 * WORDS_PER_LINE);

  lb_state_e         state_q;
  logic              front_q;
  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] base_d;
  logic              busy_q;
  logic              done_q;
  logic [9:0]        xprev_q;

  logic              trig;
  logic [9:0]        tgt_line;
  logic              tgt_valid;
  logic              ack;

  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr;
  logic [RAM_AW-1:0] ram_raddr;
  logic [RAM_AW-1:0] ram_rbase;
  logic [RAM_AW-1:0] ram_wbase;
  logic [WORD_W-1:0] ram_rdata;
  logic              pix_in_range;
  logic [LANE_W-1:0] lane_q;
  logic              pix_vld_q;

  // Edge-detect the trigger column and work out which line it targets.
  always_comb begin
    trig      = (DrawX == 10'(TRIG_X)) && (xprev_q != 10'(TRIG_X));
    tgt_line  = (DrawY == 10'(V_TOTAL - 1)) ? '0 : DrawY + 10'd1;
    tgt_valid = (32'(tgt_line) < V_ACTIVE);
    base_d    = FB_BASE + ADDR_W'(tgt_line) * ADDR_W'(WORDS_PER_LINE);
  end

  // Request/ack side: rd is gated combinationally by Wait; acks count only
  // while granted. Reset also blocks the write so a late ack is dropped.
  always_comb begin
    lb_sdram_rd   = (state_q == FETCH) && !lb_sdram_Wait;
    lb_sdram_addr = base_q + ADDR_W'(count_q);
    ack           = (state_q == FETCH) && lb_sdram_ac && !lb_sdram_Wait;
    ram_we        = ack && !reset;
    ram_wbase     = front_q ? RAM_AW'(0) : RAM_AW'(WORDS_PER_LINE);
    ram_waddr     = ram_wbase + RAM_AW'(count_q);
  end

  // Fetch FSM; a trigger in any state swaps halves and restarts (an abort
  // when it lands in FETCH). A same-cycle final ack still writes the old
  // back half because the RAM write uses the pre-swap select.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      front_q <= 1'b0;
      count_q <= '0;
      base_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      xprev_q <= '0;
    end else begin
      xprev_q <= DrawX;
      if (trig) begin
        front_q <= ~front_q;
        count_q <= '0;
        base_q  <= base_d;
        if (tgt_valid) begin
          state_q <= FETCH;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
        end else begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end else begin
        case (state_q)
          FETCH: begin
            if (ack) begin
              count_q <= count_q + 1'b1;
              if (count_q == CNT_W'(WORDS_PER_LINE - 1)) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign lb_Busy = busy_q;
  assign lb_done = done_q;

  // Pixel read address into the front half; off-screen columns read word 0
  // and are blanked downstream.
  always_comb begin
    pix_in_range = (32'(DrawX) < H_ACTIVE);
    ram_rbase    = front_q ? RAM_AW'(WORDS_PER_LINE) : RAM_AW'(0);
    ram_raddr    = pix_in_range ? ram_rbase + RAM_AW'(DrawX[9:3]) : '0;
  end

  // Lane select and blanking travel alongside the registered RAM read.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q    <= '0;
      pix_vld_q <= 1'b0;
    end else begin
      lane_q    <= DrawX[LANE_W-1:0];
      pix_vld_q <= pix_in_range;
    end
  end

  // Final pixel mux from registered state only.
  always_comb begin
    pix_data = pix_vld_q ? lb_pix_lane(ram_rdata, lane_q) : '0;
  end

  lb_line_ram #(
    .DEPTH (2 * WORDS_PER_LINE),
    .AW    (RAM_AW)
  ) u_line_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (lb_sdram_data),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

`ifdef LB_UNDERRUN_STATS_EN
  logic [15:0] ucnt_q;
  logic        uflag_q;

  // Count triggers that cut a fetch short; top-of-frame trigger clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      ucnt_q  <= '0;
      uflag_q <= 1'b0;
    end else if (trig && (DrawY == '0)) begin
      ucnt_q  <= '0;
      uflag_q <= 1'b0;
    end else if (trig && (state_q == FETCH)) begin
      if (ucnt_q != '1) begin
        ucnt_q <= ucnt_q + 16'd1;
      end
      uflag_q <= 1'b1;
    end
  end

  assign underrun_cnt  = ucnt_q;
  assign underrun_flag = uflag_q;
`else
  // Without stats an underrun simply aborts and restarts the fetch.
`endif

endmodule
